tdm_multichannel_fir_engine: RTL and testbench

- Parametrised FIR engine with N_CHANNELS channels and N_FILTERS filters that can be reloaded at run time.
- One time-multiplexed multiply-accumulate unit serves all channels, processing one tap per clock.
- Sits between the audio receive framer (which pulses new_packet once per sample frame) and the transmit serialiser.
- Adds the following over the fixed-coefficient engines: per-channel circular history, a coefficient write port, rounding and saturation, a busy/valid handshake and overrun detection.

---
 rtl/tdm_multichannel_fir_engine_if.sv | 38 +++
 rtl/tdm_multichannel_fir_engine.sv | 189 ++++++++++++++++++
 tb/tb_tdm_multichannel_fir_engine.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_multichannel_fir_engine_if.sv
// Frame/coefficient bus between the receive framer, the TDM FIR engine and the transmit serialiser.
// Handshake: a frame is taken when new_packet=1 and busy=0; new_packet or coeff_wr_en while busy=1 is dropped and pulses overrun next cycle; out_valid is a one-cycle pulse when out_data changes.
interface tdm_multichannel_fir_engine_if #(
  parameter int DATA_WIDTH  = 24,
  parameter int COEFF_WIDTH = 16,
  parameter int N_TAPS      = 89,
  parameter int N_CHANNELS  = 2,
  parameter int N_FILTERS   = 4
);
  localparam int SEL_W  = $clog2(N_FILTERS + 1);
  localparam int BANK_W = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1;
  localparam int ADDR_W = $clog2(N_TAPS);

  logic [SEL_W-1:0]                 filter_sel;
  logic                             new_packet;
  logic [N_CHANNELS*DATA_WIDTH-1:0] in_data;
  logic [N_CHANNELS*DATA_WIDTH-1:0] out_data;
  logic                             out_valid;
  logic                             busy;
  logic                             overrun;
  logic                             coeff_wr_en;
  logic [BANK_W-1:0]                coeff_wr_bank;
  logic [ADDR_W-1:0]                coeff_wr_addr;
  logic [COEFF_WIDTH-1:0]           coeff_wr_data;
  logic [1:0]                       fsm_state;

  modport master (
    output filter_sel, new_packet, in_data,
    output coeff_wr_en, coeff_wr_bank, coeff_wr_addr, coeff_wr_data,
    input  out_data, out_valid, busy, overrun, fsm_state
  );

  modport slave (
    input  filter_sel, new_packet, in_data,
    input  coeff_wr_en, coeff_wr_bank, coeff_wr_addr, coeff_wr_data,
    output out_data, out_valid, busy, overrun, fsm_state
  );
endinterface

// File: rtl/tdm_multichannel_fir_engine.sv
// Multichannel FIR with one shared MAC: per-channel circular history, reloadable coefficient banks,
// round-toward-zero scaling with saturation, busy/valid handshake and overrun reporting.
module tdm_multichannel_fir_engine #(
  parameter int DATA_WIDTH  = 24,
  parameter int COEFF_WIDTH = 16,
  parameter int FRAC_BITS   = 16,
  parameter int N_TAPS      = 89,
  parameter int N_CHANNELS  = 2,
  parameter int N_FILTERS   = 4
) (
  input  logic clk,
  input  logic rst,
  tdm_multichannel_fir_engine_if.slave bus
);
  localparam int ACC_WIDTH = DATA_WIDTH + COEFF_WIDTH + $clog2(N_TAPS);
  localparam int PROD_W    = DATA_WIDTH + COEFF_WIDTH;
  localparam int BANK_W    = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1;
  localparam int ADDR_W    = $clog2(N_TAPS);
  localparam int CH_W      = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(N_TAPS - 1);
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(N_CHANNELS - 1);
  localparam logic signed [ACC_WIDTH+1:0] SAT_MAX =
    {{(ACC_WIDTH+3-DATA_WIDTH){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH+1:0] SAT_MIN =
    {{(ACC_WIDTH+3-DATA_WIDTH){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                           state;
  logic [ADDR_W-1:0]                wptr, cur_ptr, clr_cnt, tap_cnt, rd_addr;
  logic [CH_W-1:0]                  ch_cnt, p_ch;
  logic [BANK_W-1:0]                bank_r;
  logic                             drain_cnt;
  logic                             busy_r, out_valid_r, overrun_r;
  logic [N_CHANNELS*DATA_WIDTH-1:0] out_data_r, res_pack;
  logic                             p_valid, p_first, p_last;
  logic signed [PROD_W-1:0]         prod_c, prod_r;
  logic signed [ACC_WIDTH-1:0]      acc, acc_sum, prod_ext;
  logic                             accept, sel_filtered, coeff_we;

  logic signed [DATA_WIDTH-1:0]  hist    [N_CHANNELS][N_TAPS];
  logic signed [COEFF_WIDTH-1:0] coeff   [N_FILTERS][N_TAPS];
  logic [DATA_WIDTH-1:0]         res_buf [N_CHANNELS];

  assign accept       = (state == S_IDLE) && bus.new_packet;
  assign sel_filtered = (int'(bus.filter_sel) >= 1) && (int'(bus.filter_sel) <= N_FILTERS);
  assign coeff_we     = bus.coeff_wr_en && !busy_r && !rst &&
                        (int'(bus.coeff_wr_bank) < N_FILTERS) &&
                        (int'(bus.coeff_wr_addr) < N_TAPS);

  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.overrun   = overrun_r;
  assign bus.fsm_state = state;

  // Tap k reads the sample k frames behind the frame pointer, wrapping below zero.
  always_comb begin
    if (tap_cnt <= cur_ptr) rd_addr = cur_ptr - tap_cnt;
    else                    rd_addr = ADDR_W'(int'(cur_ptr) + N_TAPS - int'(tap_cnt));
  end

  assign prod_c   = hist[ch_cnt][rd_addr] * coeff[bank_r][tap_cnt];
  assign prod_ext = {{(ACC_WIDTH-PROD_W){prod_r[PROD_W-1]}}, prod_r};
  assign acc_sum  = (p_first ? '0 : acc) + prod_ext;

  always_comb begin
    res_pack = '0;
    for (int c = 0; c < N_CHANNELS; c++) res_pack[c*DATA_WIDTH +: DATA_WIDTH] = res_buf[c];
  end

  // Magnitude shift keeps the division truncating toward zero for negative sums.
  function automatic logic [DATA_WIDTH-1:0] round_sat(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH:0]   ext;
    logic [ACC_WIDTH:0]          mag;
    logic [ACC_WIDTH:0]          q;
    logic signed [ACC_WIDTH+1:0] r;
    ext = {a[ACC_WIDTH-1], a};
    mag = a[ACC_WIDTH-1] ? -ext : ext;
    q   = mag >> FRAC_BITS;
    r   = a[ACC_WIDTH-1] ? -$signed({1'b0, q}) : $signed({1'b0, q});
    if (r > SAT_MAX)      round_sat = SAT_MAX[DATA_WIDTH-1:0];
    else if (r < SAT_MIN) round_sat = SAT_MIN[DATA_WIDTH-1:0];
    else                  round_sat = r[DATA_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (!rst && state == S_CLEAR) hist[c][clr_cnt] <= '0;
      else if (!rst && accept)      hist[c][wptr]    <= bus.in_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (coeff_we) coeff[bus.coeff_wr_bank][bus.coeff_wr_addr] <= bus.coeff_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_CLEAR;
      clr_cnt     <= '0;
      wptr        <= '0;
      cur_ptr     <= '0;
      tap_cnt     <= '0;
      ch_cnt      <= '0;
      bank_r      <= '0;
      drain_cnt   <= 1'b0;
      busy_r      <= 1'b1;
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
      out_data_r  <= '0;
      p_valid     <= 1'b0;
      p_first     <= 1'b0;
      p_last      <= 1'b0;
      p_ch        <= '0;
      prod_r      <= '0;
      acc         <= '0;
    end else begin
      out_valid_r <= 1'b0;
      overrun_r   <= busy_r && (bus.new_packet || bus.coeff_wr_en);
      p_valid     <= (state == S_RUN);
      p_first     <= (tap_cnt == '0);
      p_last      <= (tap_cnt == LAST_TAP);
      p_ch        <= ch_cnt;
      prod_r      <= prod_c;
      if (p_valid) begin
        if (p_last) res_buf[p_ch] <= round_sat(acc_sum);
        else        acc           <= acc_sum;
      end
      case (state)
        S_CLEAR: begin
          if (clr_cnt == LAST_TAP) begin
            state   <= S_IDLE;
            busy_r  <= 1'b0;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        S_IDLE: begin
          if (bus.new_packet) begin
            wptr    <= (wptr == LAST_TAP) ? '0 : wptr + ADDR_W'(1);
            cur_ptr <= wptr;
            tap_cnt <= '0;
            ch_cnt  <= '0;
            if (sel_filtered) begin
              state  <= S_RUN;
              busy_r <= 1'b1;
              bank_r <= BANK_W'(int'(bus.filter_sel) - 1);
            end else begin
              out_data_r  <= bus.in_data;
              out_valid_r <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (tap_cnt == LAST_TAP) begin
            tap_cnt <= '0;
            if (ch_cnt == LAST_CH) begin
              state     <= S_DRAIN;
              drain_cnt <= 1'b0;
            end else begin
              ch_cnt <= ch_cnt + CH_W'(1);
            end
          end else begin
            tap_cnt <= tap_cnt + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          // First cycle lets the last product reach res_buf; second publishes all channels.
          if (drain_cnt) begin
            state       <= S_IDLE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
            out_data_r  <= res_pack;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_tdm_multichannel_fir_engine.sv
// Bench for the TDM FIR engine: directed scenarios plus randomized frames against a
// shift-register/array reference model of the filter arithmetic.
module tb_tdm_multichannel_fir_engine;
  localparam int DW     = 24;
  localparam int CW     = 16;
  localparam int FRAC   = 16;
  localparam int NT     = 89;
  localparam int NC     = 2;
  localparam int NF     = 4;
  localparam int SEL_W  = $clog2(NF + 1);
  localparam int BANK_W = (NF > 1) ? $clog2(NF) : 1;
  localparam int ADDR_W = $clog2(NT);
  localparam int LAT    = NC * NT + 3;
  localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (DW - 1));

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  int m_hist [NC][NT];
  int m_coef [NF][NT];

  tdm_multichannel_fir_engine_if #(
    .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .N_TAPS(NT), .N_CHANNELS(NC), .N_FILTERS(NF)
  ) bus ();

  tdm_multichannel_fir_engine #(
    .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .FRAC_BITS(FRAC),
    .N_TAPS(NT), .N_CHANNELS(NC), .N_FILTERS(NF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // reference model
  task automatic model_clear();
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < NT; k++) m_hist[c][k] = 0;
  endtask

  task automatic model_push(input logic [NC*DW-1:0] din);
    for (int c = 0; c < NC; c++) begin
      for (int k = NT - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
      m_hist[c][0] = int'($signed(din[c*DW +: DW]));
    end
  endtask

  function automatic logic [NC*DW-1:0] model_out(input int sel, input logic [NC*DW-1:0] din);
    logic [NC*DW-1:0] res;
    longint acc;
    longint q;
    if (sel < 1 || sel > NF) return din;
    res = '0;
    for (int c = 0; c < NC; c++) begin
      acc = 0;
      for (int k = 0; k < NT; k++) acc += longint'(m_hist[c][k]) * longint'(m_coef[sel-1][k]);
      q = acc / (longint'(1) << FRAC);
      if (q > MAXV)      q = MAXV;
      else if (q < MINV) q = MINV;
      res[c*DW +: DW] = q[DW-1:0];
    end
    return res;
  endfunction

  // drivers
  task automatic write_coeff(input int b, input int a, input logic [CW-1:0] d);
    bus.coeff_wr_en   = 1'b1;
    bus.coeff_wr_bank = BANK_W'(b);
    bus.coeff_wr_addr = ADDR_W'(a);
    bus.coeff_wr_data = d;
    m_coef[b][a] = int'($signed(d));
    @(negedge clk);
    bus.coeff_wr_en = 1'b0;
  endtask

  task automatic release_reset(output int bcnt, output int ocnt, output int vcnt, input bit hold);
    bcnt = 0; ocnt = 0; vcnt = 0;
    rst = 1'b0;
    bus.new_packet = hold;
    for (int i = 0; i < NT + 6; i++) begin
      if (bus.busy === 1'b1)      bcnt++;
      if (bus.overrun === 1'b1)   ocnt++;
      if (bus.out_valid === 1'b1) vcnt++;
      bus.new_packet = hold & (bus.busy === 1'b1);
      @(negedge clk);
    end
    bus.new_packet = 1'b0;
    model_clear();
  endtask

  // disturb: 0 none, 1 extra new_packet while busy, 2 coefficient write while busy
  task automatic run_frame(input string name, input int sel, input logic [NC*DW-1:0] din,
                           input int disturb);
    logic [NC*DW-1:0] exp_v;
    bit filt;
    int n;
    filt = (sel >= 1 && sel <= NF);
    model_push(din);
    exp_v = model_out(sel, din);
    bus.filter_sel = SEL_W'(sel);
    bus.in_data    = din;
    bus.new_packet = 1'b1;
    @(negedge clk);
    bus.new_packet = 1'b0;
    n = 1;
    if (!filt) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL %s bypass_handshake valid=%b busy=%b required valid=1 busy=0",
                 name, bus.out_valid, bus.busy);
      end
      checks++;
      if (bus.out_data !== exp_v) begin
        failures++;
        $display("FAIL %s bypass_data got=%h required=%h", name, bus.out_data, exp_v);
      end
    end else begin
      checks++;
      if (bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL %s busy_after_accept got=%b required=1", name, bus.busy);
      end
      while (bus.out_valid !== 1'b1 && n < LAT + 50) begin
        if (n == 5 && disturb == 1) bus.new_packet = 1'b1;
        if (n == 5 && disturb == 2) begin
          bus.coeff_wr_en   = 1'b1;
          bus.coeff_wr_bank = '0;
          bus.coeff_wr_addr = '0;
          bus.coeff_wr_data = 16'h4000;
        end
        @(negedge clk);
        n++;
        if (n == 6 && disturb != 0) begin
          bus.new_packet  = 1'b0;
          bus.coeff_wr_en = 1'b0;
          checks++;
          if (bus.overrun !== 1'b1) begin
            failures++;
            $display("FAIL %s overrun_pulse got=%b required=1", name, bus.overrun);
          end
        end
      end
      checks++;
      if (n != LAT) begin
        failures++;
        $display("FAIL %s latency got=%0d required=%0d", name, n, LAT);
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.out_data !== exp_v) begin
        failures++;
        $display("FAIL %s result busy=%b data=%h required busy=0 data=%h",
                 name, bus.busy, bus.out_data, exp_v);
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    int bc, oc, vc;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_data !== '0 || bus.out_valid !== 1'b0 || bus.overrun !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_values data=%h valid=%b overrun=%b busy=%b required 0/0/0/1",
               bus.out_data, bus.out_valid, bus.overrun, bus.busy);
    end
    release_reset(bc, oc, vc, 1'b1);
    checks++;
    if (bc != NT) begin failures++; $display("FAIL clear_busy_cycles got=%0d required=%0d", bc, NT); end
    checks++;
    if (oc != NT) begin failures++; $display("FAIL clear_overruns got=%0d required=%0d", oc, NT); end
    checks++;
    if (vc != 0) begin failures++; $display("FAIL clear_out_valid got=%0d required=0", vc); end
  endtask

  task automatic test_impulse();
    logic [NC*DW-1:0] din;
    for (int k = 0; k < NT; k++) write_coeff(0, k, CW'(k + 1));
    for (int i = 0; i < NT; i++) begin
      din = '0;
      if (i == 0) din[0 +: DW] = 24'h010000;
      run_frame($sformatf("impulse_%0d", i), 1, din, 0);
    end
  endtask

  task automatic test_saturation();
    logic [NC*DW-1:0] din;
    for (int k = 0; k < NT; k++) write_coeff(0, k, 16'h7FFF);
    for (int i = 0; i < 6; i++) begin
      din = {24'h000000, 24'h7FFFFF};
      run_frame($sformatf("sat_pos_%0d", i), 1, din, 0);
    end
    for (int i = 0; i < 10; i++) begin
      din = {24'h000000, 24'h800000};
      run_frame($sformatf("sat_neg_%0d", i), 1, din, 0);
    end
  endtask

  task automatic test_rounding();
    write_coeff(0, 0, 16'hFFFF);
    for (int k = 1; k < NT; k++) write_coeff(0, k, 16'h0000);
    run_frame("round_one", 1, {DW'($urandom), 24'h000001}, 0);
    run_frame("round_neg", 1, {DW'($urandom), 24'hFE0000}, 0);
  endtask

  task automatic test_bypass();
    int bc;
    run_frame("bypass_sel0", 0, {24'hABCDEF, 24'h123456}, 0);
    run_frame("bypass_sel7", 7, {24'h00FF00, 24'hFEDCBA}, 0);
    bc = 0;
    repeat (4) begin
      if (bus.busy !== 1'b0) bc++;
      @(negedge clk);
    end
    checks++;
    if (bc != 0) begin failures++; $display("FAIL bypass_busy cycles=%0d required=0", bc); end
  endtask

  task automatic test_overrun();
    run_frame("ovr_packet", 1, {DW'($urandom), DW'($urandom)}, 1);
    run_frame("ovr_coeff", 1, {DW'($urandom), DW'($urandom)}, 2);
    run_frame("ovr_after", 1, {DW'($urandom), 24'h7A0000}, 0);
  endtask

  task automatic test_reset_mid_run();
    int bc, oc, vc, early;
    early = 0;
    bus.filter_sel = SEL_W'(1);
    bus.in_data    = {DW'($urandom), DW'($urandom)};
    bus.new_packet = 1'b1;
    @(negedge clk);
    bus.new_packet = 1'b0;
    repeat (100) begin
      if (bus.out_valid === 1'b1) early++;
      @(negedge clk);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    release_reset(bc, oc, vc, 1'b0);
    checks++;
    if (early + vc != 0) begin failures++; $display("FAIL abort_out_valid got=%0d required=0", early + vc); end
    checks++;
    if (bc != NT) begin failures++; $display("FAIL abort_clear_cycles got=%0d required=%0d", bc, NT); end
    run_frame("after_abort", 1, {DW'($urandom), 24'h030000}, 0);
  endtask

  task automatic test_back_to_back();
    logic [NC*DW-1:0] din;
    int sel;
    for (int b = 0; b < NF; b++)
      for (int k = 0; k < NT; k++)
        write_coeff(b, k, (b == 0) ? CW'($urandom_range(0, 65535)) : CW'($signed($urandom_range(0, 2047)) - 1024));
    for (int i = 0; i < 16; i++) begin
      sel = $urandom_range(0, (1 << SEL_W) - 1);
      for (int c = 0; c < NC; c++)
        din[c*DW +: DW] = ($urandom_range(0, 1) == 1) ? DW'($urandom) : DW'($signed($urandom_range(0, 65535)) - 32768);
      run_frame($sformatf("random_%0d_sel%0d", i, sel), sel, din, 0);
    end
  endtask

  initial begin
    bus.filter_sel    = '0;
    bus.new_packet    = 1'b0;
    bus.in_data       = '0;
    bus.coeff_wr_en   = 1'b0;
    bus.coeff_wr_bank = '0;
    bus.coeff_wr_addr = '0;
    bus.coeff_wr_data = '0;
    rst = 1'b1;
    for (int b = 0; b < NF; b++)
      for (int k = 0; k < NT; k++) m_coef[b][k] = 0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_impulse();
    test_saturation();
    test_rounding();
    test_bypass();
    test_overrun();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
